pi_pwm_driver: RTL and testbench

- Downstream stage of the PI controller; consumes its signed Q16.16 control word and drives a complementary PWM pair.
- Converts the control word to a duty count, saturates it to a legal range, and double-buffers it so that duty changes only at period boundaries.
- Inserts programmable dead time between the high-side and low-side outputs.
- Sits between the controller output register and the half-bridge gate drivers.

---
 rtl/pi_pwm_driver.sv | 153 +++++++++++++++
 tb/tb_pi_pwm_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pi_pwm_driver.sv
// Complementary PWM stage behind the PI controller: converts a Q16.16 word to a clipped,
// double-buffered duty count and drives a high/low pair with programmable dead time.
module pi_pwm_driver #(
    parameter int CNT_W    = 16,
    parameter int PERIOD   = 1000,
    parameter int DEADTIME = 8,
    parameter int DUTY_MIN = 0,
    parameter int DUTY_MAX = PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ctrl_in,
    input  logic             ctrl_valid,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic [CNT_W-1:0] duty,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             period_start
);

    typedef enum logic [1:0] {
        S_LOW,
        S_DT_LH,
        S_HIGH,
        S_DT_HL
    } state_t;

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  DT_LOAD  = CNT_W'(DEADTIME);
    localparam logic [CNT_W-1:0]  DT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(DUTY_MIN);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(DUTY_MAX);
    localparam logic signed [31:0] MIN_S   = 32'(DUTY_MIN);
    localparam logic signed [31:0] MAX_S   = 32'(DUTY_MAX);

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_duty_pend;
    logic [CNT_W-1:0]   r_duty;
    logic               r_sat_hi;
    logic               r_sat_lo;
    state_t             r_state;
    logic [CNT_W-1:0]   r_dt_cnt;

    logic signed [31:0] w_req;
    logic [CNT_W-1:0]   w_clip;
    logic               w_clip_hi;
    logic               w_clip_lo;
    logic               w_raw;

    // Integer part of the control word; the arithmetic shift floors negative fractions.
    assign w_req = $signed(ctrl_in) >>> 16;

    always_comb begin
        w_clip    = w_req[CNT_W-1:0];
        w_clip_hi = 1'b0;
        w_clip_lo = 1'b0;
        if (w_req > MAX_S) begin
            w_clip    = MAX_CNT;
            w_clip_hi = 1'b1;
        end else if (w_req < MIN_S) begin
            w_clip    = MIN_CNT;
            w_clip_lo = 1'b1;
        end
    end

    assign w_raw = (r_cnt < r_duty);

    // Period counter plus the pending/applied duty pair; duty only moves at the wrap edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_duty_pend <= MIN_CNT;
            r_duty      <= MIN_CNT;
            r_sat_hi    <= 1'b0;
            r_sat_lo    <= 1'b0;
        end else begin
            if (r_cnt == LAST_CNT) begin
                r_cnt  <= '0;
                r_duty <= r_duty_pend;
            end else begin
                r_cnt <= r_cnt + DT_ONE;
            end
            if (ctrl_valid) begin
                r_duty_pend <= w_clip;
                r_sat_hi    <= w_clip_hi;
                r_sat_lo    <= w_clip_lo;
            end
        end
    end

    // Dead-time sequencer; a raw pulse that ends inside a dead-time window never reaches HIGH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_DT_HL;
            r_dt_cnt <= DT_LOAD;
        end else begin
            case (r_state)
                S_LOW: begin
                    if (w_raw) begin
                        if (DEADTIME == 0) begin
                            r_state <= S_HIGH;
                        end else begin
                            r_state  <= S_DT_LH;
                            r_dt_cnt <= DT_LOAD;
                        end
                    end
                end
                S_DT_LH: begin
                    if (!w_raw) begin
                        r_state <= S_LOW;
                    end else if (r_dt_cnt <= DT_ONE) begin
                        r_state <= S_HIGH;
                    end else begin
                        r_dt_cnt <= r_dt_cnt - DT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!w_raw) begin
                        if (DEADTIME == 0) begin
                            r_state <= S_LOW;
                        end else begin
                            r_state  <= S_DT_HL;
                            r_dt_cnt <= DT_LOAD;
                        end
                    end
                end
                S_DT_HL: begin
                    if (w_raw) begin
                        r_state  <= S_DT_LH;
                        r_dt_cnt <= DT_LOAD;
                    end else if (r_dt_cnt <= DT_ONE) begin
                        r_state <= S_LOW;
                    end else begin
                        r_dt_cnt <= r_dt_cnt - DT_ONE;
                    end
                end
                default: begin
                    r_state  <= S_DT_HL;
                    r_dt_cnt <= DT_LOAD;
                end
            endcase
        end
    end

    assign pwm_hi       = (r_state == S_HIGH);
    assign pwm_lo       = (r_state == S_LOW);
    assign duty         = r_duty;
    assign sat_hi       = r_sat_hi;
    assign sat_lo       = r_sat_lo;
    assign period_start = (r_cnt == '0);

endmodule

// File: tb/tb_pi_pwm_driver.sv
// Directed bench for pi_pwm_driver with PERIOD=10, DEADTIME=2, duty range 0..10.
module tb_pi_pwm_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ctrl_in = '0;
    logic        ctrl_valid = 1'b0;
    logic        pwm_hi;
    logic        pwm_lo;
    logic [15:0] duty;
    logic        sat_hi;
    logic        sat_lo;
    logic        period_start;

    int passCount = 0;
    int checkCount = 0;
    logic monitorOn = 1'b0;
    logic rstAtEdge = 1'b0;
    logic armed = 1'b0;
    int gapCount = 0;
    logic [9:0] hiBits;
    logic [9:0] loBits;

    pi_pwm_driver #(
        .CNT_W(16), .PERIOD(10), .DEADTIME(2), .DUTY_MIN(0), .DUTY_MAX(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
        .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .duty(duty), .sat_hi(sat_hi),
        .sat_lo(sat_lo), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            passCount++;
    endtask

    // Drive a one-cycle ctrl_valid strobe; called and returns on a falling edge.
    task automatic applyStimulus(input logic [31:0] word);
        ctrl_in    = word;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitPeriodStart();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 20);
        if (period_start !== 1'b1) checkOutput("periodStartTimeout", 32'd0, 32'd1);
    endtask

    // Bit i of each vector is the output level while the counter equals i.
    task automatic capturePeriod(output logic [9:0] hi, output logic [9:0] lo);
        for (int i = 0; i < 10; i++) begin
            hi[i] = pwm_hi;
            lo[i] = pwm_lo;
            @(negedge clk);
        end
    endtask

    always @(posedge clk) rstAtEdge <= !rst_n;

    // Continuous checks: never both gates on, and period_start every 10 cycles outside reset.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("overlap", {31'b0, pwm_hi & pwm_lo}, 32'd0);
            gapCount++;
            if (period_start === 1'b1) begin
                if (armed && !rstAtEdge) checkOutput("periodGap", gapCount, 32'd10);
                armed    = 1'b1;
                gapCount = 0;
            end
        end
    end

    initial begin
        advance(3);
        checkOutput("rstHi", {31'b0, pwm_hi}, 32'd0);
        checkOutput("rstLo", {31'b0, pwm_lo}, 32'd0);
        checkOutput("rstDuty", {16'b0, duty}, 32'd0);
        checkOutput("rstSat", {30'b0, sat_hi, sat_lo}, 32'd0);
        checkOutput("rstPeriodStart", {31'b0, period_start}, 32'd1);
        rst_n = 1'b1;
        monitorOn = 1'b1;

        // 4.5 floors to 4: high for counts 3..4, dead time at 1..2 and 5..6
        waitPeriodStart();
        applyStimulus(32'h0004_8000);
        checkOutput("satAfter4p5", {30'b0, sat_hi, sat_lo}, 32'd0);
        checkOutput("dutyNotYet4", {16'b0, duty}, 32'd0);
        waitPeriodStart();
        checkOutput("duty4", {16'b0, duty}, 32'd4);
        capturePeriod(hiBits, loBits);
        checkOutput("duty4Hi", {22'b0, hiBits}, 32'h018);
        checkOutput("duty4Lo", {22'b0, loBits}, 32'h381);
        capturePeriod(hiBits, loBits);
        checkOutput("duty4HiAgain", {22'b0, hiBits}, 32'h018);
        checkOutput("duty4LoAgain", {22'b0, loBits}, 32'h381);

        // -2^-16 floors to -1 and clips to DUTY_MIN
        applyStimulus(32'hFFFF_FFFF);
        checkOutput("satLoNeg", {30'b0, sat_hi, sat_lo}, 32'd1);
        checkOutput("dutyHeld4", {16'b0, duty}, 32'd4);
        waitPeriodStart();
        checkOutput("duty0", {16'b0, duty}, 32'd0);
        capturePeriod(hiBits, loBits);
        checkOutput("duty0Hi", {22'b0, hiBits}, 32'h000);
        checkOutput("duty0Lo", {22'b0, loBits}, 32'h3FF);

        // 16 clips to DUTY_MAX; after the entry transient the high side stays on across wraps
        applyStimulus(32'h0010_0000);
        checkOutput("satHi16", {30'b0, sat_hi, sat_lo}, 32'd2);
        waitPeriodStart();
        checkOutput("duty10", {16'b0, duty}, 32'd10);
        capturePeriod(hiBits, loBits);
        checkOutput("duty10EntryHi", {22'b0, hiBits}, 32'h3F8);
        checkOutput("duty10EntryLo", {22'b0, loBits}, 32'h001);
        capturePeriod(hiBits, loBits);
        checkOutput("duty10Hi", {22'b0, hiBits}, 32'h3FF);
        checkOutput("duty10Lo", {22'b0, loBits}, 32'h000);

        // One-count pulse is shorter than the dead time and is swallowed
        applyStimulus(32'h0001_0000);
        checkOutput("satClear1", {30'b0, sat_hi, sat_lo}, 32'd0);
        waitPeriodStart();
        checkOutput("duty1", {16'b0, duty}, 32'd1);
        capturePeriod(hiBits, loBits);
        checkOutput("duty1ExitHi", {22'b0, hiBits}, 32'h003);
        checkOutput("duty1ExitLo", {22'b0, loBits}, 32'h3F0);
        capturePeriod(hiBits, loBits);
        checkOutput("duty1Hi", {22'b0, hiBits}, 32'h000);
        checkOutput("duty1Lo", {22'b0, loBits}, 32'h3FD);

        // Sample landing on the wrap edge waits one extra period
        advance(9);
        applyStimulus(32'h0006_0000);
        checkOutput("wrapStart", {31'b0, period_start}, 32'd1);
        checkOutput("dutyHeldAtWrap", {16'b0, duty}, 32'd1);
        capturePeriod(hiBits, loBits);
        checkOutput("duty1HiWrap", {22'b0, hiBits}, 32'h000);
        checkOutput("duty1LoWrap", {22'b0, loBits}, 32'h3FD);
        checkOutput("duty6", {16'b0, duty}, 32'd6);
        capturePeriod(hiBits, loBits);
        checkOutput("duty6Hi", {22'b0, hiBits}, 32'h078);
        checkOutput("duty6Lo", {22'b0, loBits}, 32'h201);

        // Reset in the middle of a high pulse
        advance(3);
        checkOutput("hiBeforeRst", {31'b0, pwm_hi}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstHi", {31'b0, pwm_hi}, 32'd0);
        checkOutput("midRstLo", {31'b0, pwm_lo}, 32'd0);
        checkOutput("midRstDuty", {16'b0, duty}, 32'd0);
        checkOutput("midRstCnt0", {31'b0, period_start}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstDtLo", {31'b0, pwm_lo}, 32'd0);
        @(negedge clk);
        checkOutput("postRstLo", {31'b0, pwm_lo}, 32'd1);
        checkOutput("postRstHi", {31'b0, pwm_hi}, 32'd0);
        advance(12);

        monitorOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
